usr_shift_sequencer: RTL and testbench
======================================

// Module: usr_shift_sequencer
// PURPOSE
//  - Command-driven controller for one universal shift register (USR, WIDTH bits).
//  - Per command: parallel-loads the USR, shifts it right or left N times, then returns the resulting parallel word.
//  - Streams one serial bit out per shift and feeds one serial bit in per shift.
//  - Sits between a command/response client (valid/ready) and the USR's select/data pins.
// PARAMETERS
//  WIDTH  4  USR word width; must match the attached USR
//  LEN_W  8  width of cmd_len; max shifts per command = 2**LEN_W-1
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      synchronous reset, active-high
//  cmd_valid        in   1      command offered
//  cmd_ready        out  1      command accepted when cmd_valid & cmd_ready
//  cmd_dir          in   1      0 = right shift (toward bit 0), 1 = left shift (toward bit WIDTH-1)
//  cmd_len          in   LEN_W  number of shifts
//  cmd_data         in   WIDTH  word parallel-loaded into the USR
//  ser_en           in   1      bit-clock enable; a shift occurs only in cycles with ser_en=1
//  ser_in           in   1      serial bit entering the USR on each shift
//  ser_out          out  1      bit leaving the USR on this shift
//  ser_out_valid    out  1      high exactly in cycles where a shift occurs
//  rsp_valid        out  1      result word available
//  rsp_ready        in   1      result consumed when rsp_valid & rsp_ready
//  rsp_data         out  WIDTH  USR contents after the last shift
//  usr_select       out  2      0 = hold, 1 = shift right, 2 = shift left, 3 = parallel load
//  usr_p_din        out  WIDTH  USR parallel data in
//  usr_s_left_din   out  1      USR serial in, left shift (enters bit 0)
//  usr_s_right_din  out  1      USR serial in, right shift (enters bit WIDTH-1)
//  usr_p_dout       in   WIDTH  USR parallel data out
// BEHAVIOUR
//  - States: IDLE -> LOAD -> SHIFT -> RESP -> IDLE. Fully registered FSM. All decodes from state are combinational.
//  - Reset: state = IDLE and counter = 0. While rst=1, all outputs = 0. The USR's own reset is driven by the parent.
//  - IDLE: cmd_ready = 1 and usr_select = 0. On accept: latch dir, len and data, then go to LOAD.
//  - LOAD: usr_select = 3 and usr_p_din = latched data, for exactly 1 cycle.
//      - len = 0: go to RESP.
//      - len > 0: go to SHIFT with counter = len.
//  - SHIFT:
//      - ser_en = 1: usr_select = 1 (dir 0) or 2 (dir 1); ser_out_valid = 1; counter decrements. Leave for RESP when counter reaches 0.
//      - ser_en = 0: usr_select = 0, ser_out_valid = 0, no count.
//      - ser_out = usr_p_dout[0] for a right shift, usr_p_dout[WIDTH-1] for a left shift.
//      - usr_s_right_din = ser_in only for dir 0; usr_s_left_din = ser_in only for dir 1. The unused serial input is 0.
//      - len > WIDTH is legal: bits shifted in earlier pass through to ser_out.
//  - RESP: rsp_valid = 1, rsp_data = usr_p_dout, usr_select = 0 (USR holds). Stay in RESP until rsp_ready; then go to IDLE.
//  - Latency with ser_en held at 1: accept at cycle 0, LOAD at cycle 1, shifts at cycles 2..len+1, rsp_valid from cycle len+2.
//  - cmd_ready = 0 outside IDLE, so commands offered while busy are not accepted; they wait for IDLE.
//  - Only one command is in flight; the next command can be accepted in the cycle after the rsp handshake.
//  - rst asserted mid-operation: at the next edge, return to IDLE with no response. The partial USR content is not restored.
// CONFIGURATION
//  - USR_SEQ_PARITY_EN defined:
//      - Adds output rsp_parity (1 bit) = XOR of all ser_out bits of the command.
//      - Accumulator is cleared in LOAD and updated on each shift. Valid with rsp_valid; 0 at reset.
//  - USR_SEQ_PARITY_EN undefined: the port and the accumulator are absent. All other behaviour is identical.
// STRUCTURE
//  - Package usr_seq_pkg:
//      - state enum {IDLE, LOAD, SHIFT, RESP}
//      - select constants SEL_HOLD = 2'd0, SEL_SHR = 2'd1, SEL_SHL = 2'd2, SEL_LOAD = 2'd3
//      - DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1
//  - No sub-module: the FSM and the LEN_W down-counter are inline. The bench instantiates the USR alongside this block.
// TESTING (WIDTH=4, USR attached)
//  1. rst=1 for 2 cycles -> all outputs 0. After release: cmd_ready=1, usr_select=0.
//  2. Right shift-out: data=4'b1011, dir=0, len=4, ser_in=0, ser_en=1 -> ser_out = 1,1,0,1 in cycles 2..5; rsp_data=4'b0000 at cycle 6.
//  3. Left shift-in: data=0, dir=1, len=4, ser_in = 1,0,0,1 -> ser_out all 0; rsp_data=4'b1001.
//  4. ser_en = 1,0,1,0 during SHIFT with len=2 -> ser_out_valid only in enabled cycles; usr_select=0 otherwise; rsp_valid 4 cycles after LOAD.
//  5. len=0, data=4'hA, rsp_ready=0 for 3 cycles -> rsp_data=4'hA from cycle 2, held with usr_select=0 and cmd_ready=0; IDLE after rsp_ready.
//  6. rst asserted in the 2nd SHIFT cycle -> next cycle IDLE, no rsp_valid. With USR_SEQ_PARITY_EN, rerun test 2 -> rsp_parity=1.

Source files
------------

// File: rtl/usr_seq_pkg.sv
// Shared definitions for the universal-shift-register sequencer.
//   state_t    : sequencer FSM states
//   SEL_*      : USR select-pin encodings (hold / shift right / shift left / load)
//   DIR_*      : command shift direction
package usr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    RESP
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_SHR  = 2'd1;
  localparam logic [1:0] SEL_SHL  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for one external universal shift register.
// Each accepted command parallel-loads the USR, shifts it cmd_len times in
// direction cmd_dir (one shift per ser_en cycle), then presents the USR word
// as a response held until rsp_ready.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_dir, cmd_len, cmd_data shift direction, shift count, load word
//   ser_en, ser_in             bit-clock enable, serial bit fed in per shift
//   ser_out, ser_out_valid     bit leaving the USR, high only on a shift
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   USR contents after the last shift
//   usr_select, usr_p_din      USR mode select and parallel load word
//   usr_s_left_din             USR serial in for left shifts (enters bit 0)
//   usr_s_right_din            USR serial in for right shifts (enters MSB)
//   usr_p_dout                 USR parallel output
//   rsp_parity                 XOR of the command's ser_out bits
//                              (present only with USR_SEQ_PARITY_EN defined)
//
// Build option: USR_SEQ_PARITY_EN adds the rsp_parity port and accumulator.
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_p_din,
  output logic             usr_s_left_din,
  output logic             usr_s_right_din,
`ifdef USR_SEQ_PARITY_EN
  output logic             rsp_parity,
`endif
  input  logic [WIDTH-1:0] usr_p_dout
);

  state_t           r_state;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;

  logic w_bit_out;
  logic w_shift;

  // The bit about to leave the USR depends on which end the shift pushes out.
  assign w_bit_out = (r_dir == DIR_LEFT) ? usr_p_dout[WIDTH-1] : usr_p_dout[0];
  assign w_shift   = (r_state == SHIFT) && ser_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_RIGHT;
      r_len   <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_dir   <= cmd_dir;
            r_len   <= cmd_len;
            r_data  <= cmd_data;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt <= r_len;
          if (r_len == '0) r_state <= RESP;
          else             r_state <= SHIFT;
        end
        SHIFT: begin
          if (ser_en) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == LEN_W'(1)) r_state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and forced to zero while rst is high,
  // including the very first cycles before the state register is defined.
  always_comb begin
    cmd_ready       = 1'b0;
    usr_select      = SEL_HOLD;
    usr_p_din       = '0;
    ser_out         = 1'b0;
    ser_out_valid   = 1'b0;
    usr_s_left_din  = 1'b0;
    usr_s_right_din = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = '0;
    if (!rst) begin
      unique case (r_state)
        IDLE: cmd_ready = 1'b1;
        LOAD: begin
          usr_select = SEL_LOAD;
          usr_p_din  = r_data;
        end
        SHIFT: begin
          if (ser_en) begin
            ser_out_valid = 1'b1;
            ser_out       = w_bit_out;
            if (r_dir == DIR_LEFT) begin
              usr_select     = SEL_SHL;
              usr_s_left_din = ser_in;
            end else begin
              usr_select      = SEL_SHR;
              usr_s_right_din = ser_in;
            end
          end
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_data  = usr_p_dout;
        end
        default: ;
      endcase
    end
  end

`ifdef USR_SEQ_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (r_state == LOAD) begin
      r_par <= 1'b0;
    end else if (w_shift) begin
      r_par <= r_par ^ w_bit_out;
    end
  end

  assign rsp_parity = rsp_valid & r_par;
`endif

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer with a behavioural 4-bit USR
// attached. Expected serial streams and result words come from a stream view
// of the USR: a shift register of WIDTH bits emits its contents (in shift
// order) followed by every bit fed in, and finally holds the next WIDTH bits.
module tb_usr_shift_sequencer;
  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [LW-1:0] cmd_len;
  logic [W-1:0]  cmd_data;
  logic          ser_en;
  logic          ser_in;
  logic          ser_out;
  logic          ser_out_valid;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [1:0]    usr_select;
  logic [W-1:0]  usr_p_din;
  logic          usr_s_left_din;
  logic          usr_s_right_din;
  logic [W-1:0]  usr_p_dout;
  logic          par_out;
`ifdef USR_SEQ_PARITY_EN
  logic          rsp_parity;
  assign par_out = rsp_parity;
`else
  assign par_out = 1'b0;
`endif

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dir         (cmd_dir),
    .cmd_len         (cmd_len),
    .cmd_data        (cmd_data),
    .ser_en          (ser_en),
    .ser_in          (ser_in),
    .ser_out         (ser_out),
    .ser_out_valid   (ser_out_valid),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .usr_select      (usr_select),
    .usr_p_din       (usr_p_din),
    .usr_s_left_din  (usr_s_left_din),
    .usr_s_right_din (usr_s_right_din),
`ifdef USR_SEQ_PARITY_EN
    .rsp_parity      (rsp_parity),
`endif
    .usr_p_dout      (usr_p_dout)
  );

  // Behavioural universal shift register.
  logic [W-1:0] r_usr;
  always @(posedge clk) begin
    if (rst) r_usr <= '0;
    else case (usr_select)
      2'd1: r_usr <= {usr_s_right_din, r_usr[W-1:1]};
      2'd2: r_usr <= {r_usr[W-2:0], usr_s_left_din};
      2'd3: r_usr <= usr_p_din;
      default: ;
    endcase
  end
  assign usr_p_dout = r_usr;

  logic [16:0] all_out;
  assign all_out = {par_out, cmd_ready, ser_out, ser_out_valid, rsp_valid, rsp_data,
                    usr_select, usr_p_din, usr_s_left_din, usr_s_right_din};

  int checks = 0;
  int errors = 0;

  bit outs[$], ins[$], pat[$], exp_outs[$];
  logic [W-1:0] rsp_word, exp_word;
  bit rsp_par, exp_par;
  int load_cyc, rsp_first, rsp_cycles, nsh;
  int sel_err, busy_rdy_err, hold_err;
  bit accept_ok, timed_out;

  // Drives one command and records what the DUT does, one cycle per loop.
  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic run_cmd(input bit dir, input int len, input logic [W-1:0] data,
                         input int en_mode, input int rdy_delay);
    bit done;
    outs.delete(); ins.delete();
    load_cyc = -1; rsp_first = -1; rsp_cycles = 0; nsh = 0;
    sel_err = 0; busy_rdy_err = 0; hold_err = 0; rsp_word = '0; rsp_par = 1'b0;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_len = LW'(len); cmd_data = data;
    rsp_ready = 1'b0; ser_en = 1'b1; ser_in = 1'b0;
    @(negedge clk);
    accept_ok = (cmd_ready === 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'($urandom);
    cmd_len   = LW'($urandom);
    cmd_data  = W'($urandom);
    done = 1'b0;
    for (int c = 1; c < len * 4 + 40 && !done; c++) begin
      case (en_mode)
        0:       ser_en = 1'b1;
        1:       ser_en = (c % 2 == 0);
        default: ser_en = ($urandom_range(0, 3) != 0);
      endcase
      ser_in    = (nsh < pat.size()) ? pat[nsh] : 1'($urandom);
      rsp_ready = (rsp_cycles >= rdy_delay);
      @(negedge clk);
      if (cmd_ready !== 1'b0) busy_rdy_err++;
      if (usr_select === 2'd3) load_cyc = c;
      if (c == 1) begin
        if (usr_select !== 2'd3 || usr_p_din !== data) sel_err++;
      end else if (usr_select !== (ser_out_valid ? (dir ? 2'd2 : 2'd1) : 2'd0)) begin
        sel_err++;
      end
      if (ser_out_valid === 1'b1) begin
        if (!ser_en) sel_err++;
        if (dir && (usr_s_left_din !== ser_in || usr_s_right_din !== 1'b0)) sel_err++;
        if (!dir && (usr_s_right_din !== ser_in || usr_s_left_din !== 1'b0)) sel_err++;
        outs.push_back(ser_out);
        ins.push_back(ser_in);
        nsh++;
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_first < 0) begin
          rsp_first = c;
          rsp_word  = rsp_data;
          rsp_par   = par_out;
        end else if (rsp_data !== rsp_word) begin
          hold_err++;
        end
        if (usr_select !== 2'd0) hold_err++;
        rsp_cycles++;
        if (rsp_ready) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    timed_out = !done;
    rsp_ready = 1'b0;
    ser_en    = 1'b0;
  endtask

  // Stream model: shift-order contents of the loaded word, then the fed bits.
  task automatic model_cmd(input bit dir, input int len, input logic [W-1:0] data);
    bit stream[$];
    for (int i = 0; i < W; i++) stream.push_back(dir ? data[W-1-i] : data[i]);
    foreach (ins[k]) stream.push_back(ins[k]);
    while (stream.size() < len + W) stream.push_back(1'b0);
    exp_outs.delete();
    exp_par = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_outs.push_back(stream[k]);
      exp_par ^= stream[k];
    end
    for (int j = 0; j < W; j++) begin
      if (dir) exp_word[W-1-j] = stream[len+j];
      else     exp_word[j]     = stream[len+j];
    end
  endtask

  function automatic int stream_diffs();
    int d = 0;
    if (outs.size() != exp_outs.size()) return 1000;
    foreach (outs[k]) if (outs[k] != exp_outs[k]) d++;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
        errors++; $display("FAIL reset_outputs cycle %0d got %h want 0", i, all_out);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++;
    if (usr_select !== 2'd0) begin errors++; $display("FAIL reset_select got %0d want 0", usr_select); end
    @(posedge clk); #1;
  endtask

  task automatic test_right_shift_out();
    bit want[$] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int d = 0;
    pat = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_cmd(1'b0, 4, 4'b1011, 0, 0);
    pat.delete();
    checks++;
    if (!accept_ok || timed_out) begin
      errors++; $display("FAIL right_handshake accept %b timeout %b want 1 0", accept_ok, timed_out);
    end
    if (outs.size() != 4) d = 99; else foreach (want[k]) if (outs[k] != want[k]) d++;
    checks++;
    if (d != 0) begin errors++; $display("FAIL right_ser_out got %p want 1,1,0,1", outs); end
    checks++;
    if (rsp_word !== 4'b0000) begin errors++; $display("FAIL right_rsp_data got %b want 0000", rsp_word); end
    checks++;
    if (load_cyc != 1 || rsp_first != 6) begin
      errors++; $display("FAIL right_latency load %0d rsp %0d want 1 6", load_cyc, rsp_first);
    end
    checks++;
    if (sel_err != 0 || busy_rdy_err != 0) begin
      errors++; $display("FAIL right_select sel_err %0d busy_ready %0d want 0 0", sel_err, busy_rdy_err);
    end
`ifdef USR_SEQ_PARITY_EN
    checks++;
    if (rsp_par !== 1'b1) begin errors++; $display("FAIL right_parity got %b want 1", rsp_par); end
`endif
  endtask

  task automatic test_left_shift_in();
    int ones = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_cmd(1'b1, 4, 4'b0000, 0, 0);
    pat.delete();
    foreach (outs[k]) if (outs[k]) ones++;
    checks++;
    if (outs.size() != 4 || ones != 0) begin
      errors++; $display("FAIL left_ser_out count %0d ones %0d want 4 0", outs.size(), ones);
    end
    checks++;
    if (rsp_word !== 4'b1001) begin errors++; $display("FAIL left_rsp_data got %b want 1001", rsp_word); end
    checks++;
    if (sel_err != 0 || timed_out || rsp_first != 6) begin
      errors++; $display("FAIL left_timing sel_err %0d timeout %b rsp %0d want 0 0 6", sel_err, timed_out, rsp_first);
    end
  endtask

  task automatic test_ser_en_gaps();
    bit dir = 1'($urandom);
    logic [W-1:0] data = W'($urandom);
    run_cmd(dir, 2, data, 1, 0);
    model_cmd(dir, 2, data);
    checks++;
    if (nsh != 2 || sel_err != 0) begin
      errors++; $display("FAIL gaps_shifts got %0d sel_err %0d want 2 0", nsh, sel_err);
    end
    checks++;
    if (load_cyc != 1 || rsp_first != 5) begin
      errors++; $display("FAIL gaps_latency load %0d rsp %0d want 1 5", load_cyc, rsp_first);
    end
    checks++;
    if (stream_diffs() != 0 || rsp_word !== exp_word) begin
      errors++; $display("FAIL gaps_data rsp %b want %b stream %p want %p", rsp_word, exp_word, outs, exp_outs);
    end
  endtask

  task automatic test_len_zero_backpressure();
    run_cmd(1'b0, 0, 4'hA, 0, 3);
    checks++;
    if (rsp_first != 2 || rsp_word !== 4'hA) begin
      errors++; $display("FAIL len0_rsp cycle %0d data %h want 2 a", rsp_first, rsp_word);
    end
    checks++;
    if (rsp_cycles != 4 || hold_err != 0 || busy_rdy_err != 0 || outs.size() != 0) begin
      errors++; $display("FAIL len0_hold cycles %0d hold_err %0d busy_ready %0d shifts %0d want 4 0 0 0",
                         rsp_cycles, hold_err, busy_rdy_err, outs.size());
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL len0_idle ready %b rsp_valid %b want 1 0", cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int rv = 0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = LW'(4); cmd_data = W'($urandom);
    ser_en = 1'b1; ser_in = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;          // LOAD done, first SHIFT cycle now
    @(posedge clk); #1;          // second SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrst_outputs got %h want 0", all_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || usr_select !== 2'd0) begin
      errors++; $display("FAIL midrst_idle ready %b select %0d want 1 0", cmd_ready, usr_select);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ser_out_valid !== 1'b0) rv++;
    end
    checks++;
    if (rv != 0) begin errors++; $display("FAIL midrst_no_rsp active cycles %0d want 0", rv); end
    rsp_ready = 1'b0; ser_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      bit dir = 1'($urandom);
      int len = $urandom_range(0, 12);
      logic [W-1:0] data = W'($urandom);
      run_cmd(dir, len, data, 2, $urandom_range(0, 3));
      model_cmd(dir, len, data);
      checks++;
      if (!accept_ok || timed_out || nsh != len) begin
        errors++; $display("FAIL rand_flow cmd %0d accept %b timeout %b shifts %0d want 1 0 %0d",
                           n, accept_ok, timed_out, nsh, len);
      end
      checks++;
      if (stream_diffs() != 0 || rsp_word !== exp_word) begin
        errors++; $display("FAIL rand_data cmd %0d dir %b len %0d rsp %b want %b stream %p want %p",
                           n, dir, len, rsp_word, exp_word, outs, exp_outs);
      end
      checks++;
      if (sel_err != 0 || hold_err != 0 || busy_rdy_err != 0 || load_cyc != 1) begin
        errors++; $display("FAIL rand_ctrl cmd %0d sel %0d hold %0d busy %0d load %0d want 0 0 0 1",
                           n, sel_err, hold_err, busy_rdy_err, load_cyc);
      end
`ifdef USR_SEQ_PARITY_EN
      checks++;
      if (rsp_par !== exp_par) begin
        errors++; $display("FAIL rand_parity cmd %0d got %b want %b", n, rsp_par, exp_par);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      bit dir = 1'($urandom);
      int len = $urandom_range(1, 6);
      logic [W-1:0] data = W'($urandom);
      run_cmd(dir, len, data, 0, 0);
      model_cmd(dir, len, data);
      checks++;
      if (!accept_ok || rsp_first != len + 2 || rsp_word !== exp_word) begin
        errors++; $display("FAIL b2b cmd %0d accept %b rsp_cycle %0d data %b want 1 %0d %b",
                           n, accept_ok, rsp_first, rsp_word, exp_word, len + 2, exp_word);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0;
    ser_en = 1'b0; ser_in = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_right_shift_out();
    test_left_shift_in();
    test_ser_en_gaps();
    test_len_zero_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
